// File: rtl/ft_fifo_bridge.sv
// ft_fifo_bridge: FT2232H sync-FIFO bridge between host bus and in/out FIFOs; FT_SEND_IMMEDIATE_EN enables SIWU pulse
module ft_fifo_bridge #(
  parameter int BURST_MAX = 64
) (
  input  logic       clk_60000000_i,
  input  logic       reset_i,
  input  logic       ft_rxf_n_i,
  input  logic       ft_txe_n_i,
  input  logic [7:0] ft_data_i,
  output logic [7:0] ft_data_o,
  output logic       ft_data_oe_o,
  output logic       ft_oe_n_o,
  output logic       ft_rd_n_o,
  output logic       ft_wr_n_o,
  output logic       ft_siwu_n_o,
  output logic       wr_in_fifo_en_o,
  output logic [7:0] wr_in_fifo_data_o,
  input  logic       wr_in_fifo_afull_i,
  output logic       rd_out_fifo_en_o,
  input  logic [7:0] rd_out_fifo_data_i,
  input  logic       rd_out_fifo_empty_i
);
`ifdef FT_SEND_IMMEDIATE_EN
  localparam logic SIWU_EN = 1'b1;
`else
  localparam logic SIWU_EN = 1'b0;
`endif
  localparam logic [6:0] BM = 7'(BURST_MAX);
  typedef enum logic [2:0] {IDLE, RD_OE, RD, WR, TURN} state_t;
  state_t state, state_n;
  logic [6:0] burst, burst_n;
  logic [7:0] skid [2];
  logic [7:0] head_n;
  logic [1:0] cnt, cnt_n;
  logic rp, wp, pop_q, wr_prio;
  logic cap_rd, acc, rd_go, wr_go, wr_done, rd_end, wr_end, en_n;
  // next-state, skid bookkeeping and burst accounting
  always_comb begin
    cap_rd = ~ft_rd_n_o & ~ft_rxf_n_i;
    acc = ~ft_wr_n_o & ~ft_txe_n_i;
    cnt_n = cnt + 2'(pop_q) - 2'(acc);
    head_n = (cnt == {1'b0, acc}) ? rd_out_fifo_data_i : skid[rp ^ acc];
    burst_n = (burst == BM) ? burst : burst + 7'(cap_rd | acc);
    rd_go = ~ft_rxf_n_i & ~wr_in_fifo_afull_i;
    wr_go = ~ft_txe_n_i & ((cnt != 2'd0) | ~rd_out_fifo_empty_i);
    wr_done = (cnt_n == 2'd0) & rd_out_fifo_empty_i & ~rd_out_fifo_en_o;
    rd_end = ft_rxf_n_i | wr_in_fifo_afull_i | (burst_n == BM);
    wr_end = ft_txe_n_i | wr_done | (burst_n == BM);
    state_n = state == IDLE  ? (rd_go & ~(wr_go & wr_prio) ? RD_OE : wr_go ? WR : IDLE) :
              state == RD_OE ? RD :
              state == RD    ? (rd_end ? TURN : RD) :
              state == WR    ? (wr_end ? TURN : WR) : IDLE;
    en_n = (state_n == WR) & ~rd_out_fifo_empty_i & ~rd_out_fifo_en_o & (cnt_n < 2'd2);
  end
  // state, registered outputs and 2-entry write skid
  always_ff @(posedge clk_60000000_i) begin
    if (reset_i) begin
      state <= IDLE;
      burst <= '0;
      cnt <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      pop_q <= 1'b0;
      wr_prio <= 1'b0;
      skid[0] <= '0;
      skid[1] <= '0;
      ft_data_o <= '0;
      ft_data_oe_o <= 1'b0;
      ft_oe_n_o <= 1'b1;
      ft_rd_n_o <= 1'b1;
      ft_wr_n_o <= 1'b1;
      ft_siwu_n_o <= 1'b1;
      wr_in_fifo_en_o <= 1'b0;
      wr_in_fifo_data_o <= '0;
      rd_out_fifo_en_o <= 1'b0;
    end else begin
      state <= state_n;
      burst <= (state == IDLE) ? '0 : burst_n;
      cnt <= cnt_n;
      rp <= rp ^ acc;
      wp <= wp ^ pop_q;
      pop_q <= rd_out_fifo_en_o;
      if (pop_q) skid[wp] <= rd_out_fifo_data_i;
      wr_prio <= (state == IDLE && state_n != IDLE) ? 1'b0 :
                 (state == RD && rd_end) ? (burst_n == BM) : wr_prio;
      ft_data_o <= head_n;
      ft_data_oe_o <= state_n == WR;
      ft_oe_n_o <= ~(state_n == RD_OE || state_n == RD);
      ft_rd_n_o <= ~(state_n == RD);
      ft_wr_n_o <= ~(state_n == WR && cnt_n != 2'd0);
      ft_siwu_n_o <= ~(SIWU_EN & (state == WR) & (state_n == TURN) & (burst_n != 7'd0) & wr_done);
      wr_in_fifo_en_o <= cap_rd;
      wr_in_fifo_data_o <= cap_rd ? ft_data_i : wr_in_fifo_data_o;
      rd_out_fifo_en_o <= en_n;
    end
  end
endmodule

// File: tb/tb_ft_fifo_bridge.sv
// tb_ft_fifo_bridge: directed scoreboard bench for ft_fifo_bridge
module tb_ft_fifo_bridge;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic ft_rxf_n_i = 1'b1;
  logic ft_txe_n_i = 1'b1;
  logic [7:0] ft_data_i = '0;
  logic [7:0] ft_data_o;
  logic ft_data_oe_o, ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, ft_siwu_n_o;
  logic wr_in_fifo_en_o;
  logic [7:0] wr_in_fifo_data_o;
  logic wr_in_fifo_afull_i = 1'b0;
  logic rd_out_fifo_en_o;
  logic [7:0] rd_out_fifo_data_i = '0;
  logic rd_out_fifo_empty_i = 1'b1;
  int total = 0, bad = 0;
  int n_push = 0, n_acc = 0, n_rdoe = 0, n_siwu = 0, host_i = 0, base, hold;
  logic [7:0] host_q[$], exp_rd[$], exp_wr[$], ofifo[$];
  bit kinds[$];
  int rd_len[$];
  logic prev_oe = 1'b1, prev_doe = 1'b0;

  always #8 clk = ~clk;

  ft_fifo_bridge dut (
    .clk_60000000_i(clk), .reset_i(reset_i),
    .ft_rxf_n_i(ft_rxf_n_i), .ft_txe_n_i(ft_txe_n_i),
    .ft_data_i(ft_data_i), .ft_data_o(ft_data_o), .ft_data_oe_o(ft_data_oe_o),
    .ft_oe_n_o(ft_oe_n_o), .ft_rd_n_o(ft_rd_n_o), .ft_wr_n_o(ft_wr_n_o),
    .ft_siwu_n_o(ft_siwu_n_o),
    .wr_in_fifo_en_o(wr_in_fifo_en_o), .wr_in_fifo_data_o(wr_in_fifo_data_o),
    .wr_in_fifo_afull_i(wr_in_fifo_afull_i),
    .rd_out_fifo_en_o(rd_out_fifo_en_o), .rd_out_fifo_data_i(rd_out_fifo_data_i),
    .rd_out_fifo_empty_i(rd_out_fifo_empty_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_host();
    ft_rxf_n_i = host_i >= host_q.size();
    ft_data_i = (host_i < host_q.size()) ? host_q[host_i] : 8'h00;
  endtask

  task automatic load_host(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      host_q.push_back(8'(b + i));
      exp_rd.push_back(8'(b + i));
    end
    drive_host();
  endtask

  task automatic load_out(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      ofifo.push_back(8'(b + i));
      exp_wr.push_back(8'(b + i));
    end
    rd_out_fifo_empty_i = 1'b0;
  endtask

  task automatic tick();
    logic rd_x, wr_x, pop;
    @(negedge clk);
    rd_x = !ft_rd_n_o && !ft_rxf_n_i;
    wr_x = !ft_wr_n_o && !ft_txe_n_i;
    pop = rd_out_fifo_en_o;
    chk("no_bus_clash", !(ft_data_oe_o && !ft_oe_n_o), 1);
    if (wr_in_fifo_en_o) begin
      n_push++;
      chk("push_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) chk("push_data", wr_in_fifo_data_o, exp_rd.pop_front());
    end
    if (wr_x) begin
      n_acc++;
      chk("accept_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) chk("accept_data", ft_data_o, exp_wr.pop_front());
    end
    if (pop) chk("pop_nonempty", ofifo.size() != 0, 1);
    if (!ft_oe_n_o && ft_rd_n_o) n_rdoe++;
    if (!ft_siwu_n_o) begin
      n_siwu++;
      chk("siwu_in_turn", {ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, ft_data_oe_o}, 4'b1110);
    end
    if (prev_oe && !ft_oe_n_o) begin
      kinds.push_back(1'b1);
      rd_len.push_back(0);
    end
    if (!prev_doe && ft_data_oe_o) kinds.push_back(1'b0);
    if (rd_x && rd_len.size() != 0) rd_len[rd_len.size() - 1] = rd_len[rd_len.size() - 1] + 1;
    prev_oe = ft_oe_n_o;
    prev_doe = ft_data_oe_o;
    @(posedge clk);
    #1;
    if (rd_x) host_i++;
    if (pop && ofifo.size() != 0) rd_out_fifo_data_i = ofifo.pop_front();
    rd_out_fifo_empty_i = ofifo.size() == 0;
    drive_host();
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    chk("rst_strobes", {ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, ft_siwu_n_o}, 4'b1111);
    chk("rst_enables", {ft_data_oe_o, wr_in_fifo_en_o, rd_out_fifo_en_o}, 3'b000);
    chk("rst_ft_data", ft_data_o, 8'h00);
    chk("rst_in_data", wr_in_fifo_data_o, 8'h00);
    reset_i = 1'b0;
    // both sides idle: stay idle with strobes high
    repeat (4) tick();
    chk("idle_strobes", {ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, ft_data_oe_o}, 4'b1110);
    // 10-byte host read
    n_rdoe = 0;
    n_push = 0;
    load_host(10, 8'h01);
    for (int k = 0; k < 60 && exp_rd.size() != 0; k++) tick();
    repeat (3) tick();
    chk("rd10_rdoe_cycles", n_rdoe, 1);
    chk("rd10_pushes", n_push, 10);
    chk("rd10_left", exp_rd.size(), 0);
    chk("rd10_turn_idle", {ft_oe_n_o, ft_rd_n_o}, 2'b11);
    // write with a 4-cycle txe pause after 2 accepts
    base = n_acc;
    load_out(5, 8'hA0);
    ft_txe_n_i = 1'b0;
    for (int k = 0; k < 60 && n_acc - base < 2; k++) tick();
    ft_txe_n_i = 1'b1;
    tick();
    tick();
    chk("pause_wr_high_a", ft_wr_n_o, 1'b1);
    tick();
    tick();
    chk("pause_wr_high_b", ft_wr_n_o, 1'b1);
    chk("pause_accepts", n_acc - base, 2);
    ft_txe_n_i = 1'b0;
    for (int k = 0; k < 100 && exp_wr.size() != 0; k++) tick();
    repeat (6) tick();
    chk("pause_total_accepts", n_acc - base, 5);
    chk("pause_left", exp_wr.size(), 0);
    chk("pause_wr_idle", ft_wr_n_o, 1'b1);
    ft_txe_n_i = 1'b1;
    // almost-full during a read burst
    n_push = 0;
    load_host(30, 8'h40);
    for (int k = 0; k < 60 && n_push < 5; k++) tick();
    wr_in_fifo_afull_i = 1'b1;
    tick();
    tick();
    chk("afull_rd_high", ft_rd_n_o, 1'b1);
    hold = host_i;
    repeat (5) tick();
    chk("afull_no_more_reads", host_i, hold);
    chk("afull_all_pushed", exp_rd.size(), host_q.size() - host_i);
    wr_in_fifo_afull_i = 1'b0;
    for (int k = 0; k < 120 && exp_rd.size() != 0; k++) tick();
    chk("afull_drained", exp_rd.size(), 0);
    repeat (3) tick();
    // both sides pending with bursts capped at 64
    kinds.delete();
    rd_len.delete();
    load_host(200, 8'h00);
    load_out(10, 8'hB0);
    ft_txe_n_i = 1'b0;
    for (int k = 0; k < 2000 && (exp_rd.size() != 0 || exp_wr.size() != 0); k++) tick();
    repeat (4) tick();
    chk("mix_rd_left", exp_rd.size(), 0);
    chk("mix_wr_left", exp_wr.size(), 0);
    chk("mix_bursts", kinds.size() >= 3 && rd_len.size() >= 2, 1);
    if (kinds.size() >= 3 && rd_len.size() >= 2) begin
      chk("mix_first_read", kinds[0], 1'b1);
      chk("mix_first_len", rd_len[0], 64);
      chk("mix_then_write", kinds[1], 1'b0);
      chk("mix_read_again", kinds[2], 1'b1);
      chk("mix_second_len", rd_len[1], 64);
    end
    // reset in the middle of a write burst
    base = n_acc;
    load_out(8, 8'hC0);
    for (int k = 0; k < 60 && n_acc - base < 2; k++) tick();
    reset_i = 1'b1;
    tick();
    chk("mrst_strobes", {ft_oe_n_o, ft_rd_n_o, ft_wr_n_o, ft_siwu_n_o}, 4'b1111);
    chk("mrst_enables", {ft_data_oe_o, wr_in_fifo_en_o, rd_out_fifo_en_o}, 3'b000);
    chk("mrst_ft_data", ft_data_o, 8'h00);
    tick();
    ofifo.delete();
    exp_wr.delete();
    rd_out_fifo_empty_i = 1'b1;
    reset_i = 1'b0;
    repeat (6) tick();
    chk("mrst_skid_empty", {ft_wr_n_o, ft_data_oe_o}, 2'b10);
    // 3-byte write that drains the FIFO
    n_siwu = 0;
    load_out(3, 8'hD0);
    for (int k = 0; k < 60 && exp_wr.size() != 0; k++) tick();
    repeat (6) tick();
    chk("siwu_wr_left", exp_wr.size(), 0);
`ifdef FT_SEND_IMMEDIATE_EN
    chk("siwu_pulses", n_siwu, 1);
`else
    chk("siwu_pulses", n_siwu, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ft_fifo_bridge.md
FT_FIFO_BRIDGE -- requirements
Module: ft_fifo_bridge

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 64, giving the maximum bytes per direction per burst (legal range 1..127).
REQ-002 The block SHALL have these ports, one clock and one reset: the reset is synchronous and active-high.
- clk_60000000_i  in  1  FT2232H CLKOUT; all logic is on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ft_rxf_n_i  in  1  FT has host data available (low).
- ft_txe_n_i  in  1  FT can accept a byte (low).
- ft_data_i  in  8  FT data bus, read direction.
- ft_data_o  out  8  FT data bus, write direction.
- ft_data_oe_o  out  1  drive ft_data_o onto the pad.
- ft_oe_n_o  out  1  FT output enable (low).
- ft_rd_n_o  out  1  FT read strobe (low).
- ft_wr_n_o  out  1  FT write strobe (low).
- ft_siwu_n_o  out  1  FT send-immediate (low).
- wr_in_fifo_en_o  out  1  push to the input FIFO.
- wr_in_fifo_data_o  out  8  input FIFO push data.
- wr_in_fifo_afull_i  in  1  input FIFO almost full (at least 3 free slots remain when it rises).
- rd_out_fifo_en_o  out  1  pop from the output FIFO.
- rd_out_fifo_data_i  in  8  output FIFO data, valid 1 cycle after a pop.
- rd_out_fifo_empty_i  in  1  output FIFO empty.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The state machine SHALL have the states IDLE, RD_OE, RD, WR and TURN.
REQ-005 In IDLE, the block SHALL go to RD_OE when ~ft_rxf_n_i & ~wr_in_fifo_afull_i, and to WR when ~ft_txe_n_i & (skid nonempty | ~rd_out_fifo_empty_i).
REQ-006 When both IDLE conditions hold, read SHALL win, except that write SHALL win once when the previous read burst ended on BURST_MAX.
REQ-007 RD_OE SHALL last exactly 1 cycle, with ft_oe_n_o=0 and ft_rd_n_o=1, and then go to RD.
REQ-008 In RD, ft_oe_n_o and ft_rd_n_o SHALL both be 0.
REQ-009 A byte SHALL be captured from ft_data_i at each edge where ft_rd_n_o=0 & ft_rxf_n_i=0.
REQ-010 Each captured byte SHALL appear on wr_in_fifo_data_o with a 1-cycle wr_in_fifo_en_o pulse on the following cycle.
REQ-011 Captured bytes SHALL never be dropped or duplicated.
REQ-012 RD SHALL exit to TURN when ft_rxf_n_i=1, when wr_in_fifo_afull_i=1, or when the burst count reaches BURST_MAX.
REQ-013 On RD exit, ft_rd_n_o and ft_oe_n_o SHALL go to 1 on the next edge.
REQ-014 The write path SHALL use a 2-entry skid buffer.
REQ-015 rd_out_fifo_en_o SHALL be asserted only when ~rd_out_fifo_empty_i, the state is WR, and (skid occupancy + pops in flight) < 2.
REQ-016 In WR, ft_data_oe_o SHALL be 1, and ft_data_o SHALL be the skid head.
REQ-017 ft_wr_n_o SHALL be 0 while the skid is nonempty.
REQ-018 A byte SHALL count as accepted at an edge where ft_wr_n_o=0 & ft_txe_n_i=0.
REQ-019 ft_data_o SHALL stay stable until its byte is accepted.
REQ-020 WR SHALL exit to TURN when the skid and the output FIFO are both empty with no pop in flight, when ft_txe_n_i=1, or when the burst count reaches BURST_MAX.
REQ-021 Bytes left unsent SHALL stay in the skid, and any in-flight pop SHALL still land in the skid.
REQ-022 TURN SHALL last exactly 1 cycle with ft_data_oe_o=0, ft_oe_n_o=1, ft_rd_n_o=1 and ft_wr_n_o=1, and then go to IDLE.
REQ-023 ft_data_oe_o=1 and ft_oe_n_o=0 SHALL never occur in the same cycle.
REQ-024 The burst counter SHALL be 7 bits, SHALL clear on entry to RD or WR, SHALL increment per transferred byte, and SHALL never wrap.
REQ-025 If ft_rxf_n_i and ft_txe_n_i are both high, the block SHALL stay in IDLE with all strobes high.

Reset
REQ-026 While reset_i=1, the state SHALL be IDLE.
REQ-027 While reset_i=1, ft_oe_n_o, ft_rd_n_o, ft_wr_n_o and ft_siwu_n_o SHALL be 1.
REQ-028 While reset_i=1, ft_data_oe_o, wr_in_fifo_en_o and rd_out_fifo_en_o SHALL be 0.
REQ-029 While reset_i=1, ft_data_o and wr_in_fifo_data_o SHALL be 8'h00, the skid SHALL be empty, and the burst counter SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst; in-flight bytes are discarded, and all strobes SHALL be high on the first edge with reset_i=1.

Configuration
REQ-031 With FT_SEND_IMMEDIATE_EN defined, ft_siwu_n_o SHALL pulse low for exactly the TURN cycle after a WR burst that sent at least 1 byte and ended with the skid and the output FIFO both empty.
REQ-032 Without FT_SEND_IMMEDIATE_EN, ft_siwu_n_o SHALL be constant 1.

Verification
REQ-033 Host sends 10 bytes 0x01..0x0A with ft_rxf_n_i low throughout -> RD_OE for 1 cycle, then 10 wr_in_fifo_en_o pulses carrying 0x01..0x0A in order, then TURN.
REQ-034 Output FIFO holds 5 bytes 0xA0..0xA4, and ft_txe_n_i goes high after 2 accepts for 4 cycles -> 0xA0, 0xA1 accepted, ft_wr_n_o high, WR re-entered later, 0xA2..0xA4 sent with no loss or duplicate.
REQ-035 Both sides pending with 200 host bytes and BURST_MAX=64 -> read 64, TURN, write burst, TURN, read again; the turnaround rule holds throughout.
REQ-036 wr_in_fifo_afull_i rises during a read burst -> ft_rd_n_o high on the next edge, and all captured bytes are pushed.
REQ-037 Reset pulsed during a WR burst -> all strobes high and ft_data_oe_o=0 on the next edge, skid empty; with FT_SEND_IMMEDIATE_EN, a 3-byte write that drains the FIFO gives a 1-cycle ft_siwu_n_o low in TURN.
